wb_sched: RTL
=============

Name: wb_sched

Overview:
- Writeback scheduler and scoreboard for the 64-entry, 32-bit integer/float register file.
- Shares the register file's single write port among three producers: load unit, FPU and ALU.
- Tracks pending destination registers and stalls issue on RAW/WAW hazards against in-flight multi-cycle results.
- Sits between the decode/issue stage, the execution units and the register file write port.

Parameters:
- NREG, 64, number of architectural registers.
- AW, 6, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- iss_valid  in  1  decode presents an instruction
- iss_rs1  in  AW  source 1 address
- iss_rs2  in  AW  source 2 address
- iss_rd  in  AW  destination address
- iss_rd_we  in  1  instruction writes rd
- iss_stall  out  1  hazard; issue must hold (combinational)
- req_valid  in  3  per-producer writeback request; bit0 load, bit1 FPU, bit2 ALU
- req_addr  in  3*AW  per-producer destination, packed by bit index
- req_data  in  3*DW  per-producer result, packed by bit index
- req_ready  out  3  one-hot grant; the request is consumed on the clk edge where valid&ready (combinational)
- rf_we  out  1  register file write enable (registered)
- rf_a3  out  AW  register file write address (registered)
- rf_wd  out  DW  register file write data (registered)

Behaviour:
- **Reset (rstn low, async):**
  - pending[NREG-1:0]=0, rr_ptr=0.
  - rf_we=0, rf_a3=0, rf_wd=0.
  - Combinational outputs follow from this state: req_ready=0 when no request is valid; iss_stall=0 when iss_valid=0.
  - Reset asserted mid-operation drops any granted-but-unwritten result.
- **Arbitration (round-robin, combinational):**
  - Search starts at rr_ptr, scanning bits rr_ptr, rr_ptr+1, rr_ptr+2 mod 3.
  - The first valid requester found gets req_ready.
  - On a grant to index g, rr_ptr <= (g+1) mod 3.
  - With no valid request, rr_ptr holds.
  - At most one grant per cycle.
  - Any requester continuously valid is granted within 3 cycles.
- **Write stage (1-cycle latency):**
  - On a grant: rf_we <= (addr!=0), rf_a3 <= addr, rf_wd <= data.
  - Otherwise rf_we <= 0; rf_a3 and rf_wd hold.
  - A write to r0 is granted and consumed but never reaches the register file.
- **Scoreboard:**
  - Issue is accepted when iss_valid & ~iss_stall.
  - Set: on an accepted issue with iss_rd_we & iss_rd!=0, pending[iss_rd] <= 1.
  - Clear: on a grant with addr!=0, pending[addr] <= 0. The value appears on rf_* in the same edge, and the register file forwards rf_wd on a matching read, so readers may issue from the next cycle.
  - Set and clear of the same register in the same cycle: set wins (new in-flight producer).
  - pending[0] is constantly 0.
- **Stall (combinational):** iss_stall = iss_valid & ( hit(rs1) | hit(rs2) | (iss_rd_we & hit(rd)) ).
  - hit(r) = pending[r] & ~(grant_now & grant_addr==r).
  - A register being granted this cycle is not a hazard. Its value is written at the edge and forwarded by the register file thereafter.
  - r0 never hits.
- **Producer obligations:**
  - Hold addr and data stable while valid & ~ready.
  - Never request writeback for a register not marked pending; behaviour in that case is unspecified, but a grant must not corrupt other pending bits.

Optional Feature:
- Macro: WB_SCHED_PERF_EN.
- **Defined:** adds two extra output ports.
  - stall_cnt, 32-bit: counts cycles with iss_stall=1.
  - conflict_cnt, 32-bit: counts cycles with 2 or more bits of req_valid set.
  - Both reset to 0 and wrap modulo 2^32.
- **Undefined:** ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then 10 idle cycles -> rf_we=0, iss_stall=0 for an issue of rs1=5,rs2=6,rd=7, and pending[7]=1 the next cycle.
- Issue rd=7 (accepted); next cycle issue rs1=7 -> iss_stall=1. Load requests addr=7, data=0xDEADBEEF -> req_ready=001 and iss_stall=0 in that same cycle; next cycle rf_we=1, rf_a3=7, rf_wd=0xDEADBEEF and pending[7]=0.
- All three requesters valid for 6 cycles from reset (rr_ptr=0), each dropping valid after its grant -> grants 001, 010, 100, then idle; rr_ptr ends at 0.
- ALU requests addr=0, data=0x1234 -> req_ready=100, rf_we stays 0 the following cycle.
- Issue rd=9 while the FPU is granted addr=9 in the same cycle -> no stall (WAW cleared); pending[9]=1 after the edge (set wins).
- Drop rstn asynchronously mid-cycle with pending[3]=1 and rf_we=1 -> rf_we=0 and pending=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/wb_sched.sv
// rtl/wb_sched.sv - round-robin writeback arbiter and RAW/WAW scoreboard for the shared RF write port
// WB_SCHED_PERF_EN adds stall_cnt and conflict_cnt outputs.
module wb_sched #(
  parameter int NREG = 64,
  parameter int AW   = 6,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_rd_we,
  output logic            iss_stall,
  input  logic [2:0]      req_valid,
  input  logic [3*AW-1:0] req_addr,
  input  logic [3*DW-1:0] req_data,
  output logic [2:0]      req_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [DW-1:0]   rf_wd
`ifdef WB_SCHED_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     conflict_cnt
`endif
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [1:0]      rr_ptr;
  logic [2:0]      scan;
  logic            grant_now;
  logic [1:0]      grant_idx;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   grant_data;
  logic            hit_rs1;
  logic            hit_rs2;
  logic            hit_rd;
  logic            issue_ok;

  always_comb begin
    grant_now = 1'b0;
    grant_idx = 2'd0;
    scan      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      scan = {1'b0, rr_ptr} + 3'(k);
      if (scan >= 3'd3) scan = scan - 3'd3;
      if (!grant_now && req_valid[scan[1:0]]) begin
        grant_now = 1'b1;
        grant_idx = scan[1:0];
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd1:    begin grant_addr = req_addr[AW +: AW];   grant_data = req_data[DW +: DW];   end
      2'd2:    begin grant_addr = req_addr[2*AW +: AW]; grant_data = req_data[2*DW +: DW]; end
      default: begin grant_addr = req_addr[0 +: AW];    grant_data = req_data[0 +: DW];    end
    endcase
  end

  assign req_ready = grant_now ? (3'b001 << grant_idx) : 3'b000;

  // A register granted this cycle lands at the edge and is forwarded by the RF, so it is not a hazard.
  assign hit_rs1   = pending[iss_rs1] & ~(grant_now & (grant_addr == iss_rs1));
  assign hit_rs2   = pending[iss_rs2] & ~(grant_now & (grant_addr == iss_rs2));
  assign hit_rd    = pending[iss_rd]  & ~(grant_now & (grant_addr == iss_rd));
  assign iss_stall = iss_valid & (hit_rs1 | hit_rs2 | (iss_rd_we & hit_rd));
  assign issue_ok  = iss_valid & ~iss_stall & iss_rd_we & (iss_rd != '0);

  always_comb begin
    pending_nxt = pending;
    if (grant_now) pending_nxt[grant_addr] = 1'b0;
    // Set after clear: a new in-flight producer overrides the retiring one.
    if (issue_ok) pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
      rr_ptr  <= 2'd0;
      rf_we   <= 1'b0;
      rf_a3   <= '0;
      rf_wd   <= '0;
    end else begin
      pending <= pending_nxt;
      rf_we   <= 1'b0;
      if (grant_now) begin
        rr_ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        rf_we  <= (grant_addr != '0);
        rf_a3  <= grant_addr;
        rf_wd  <= grant_data;
      end
    end
  end

`ifdef WB_SCHED_PERF_EN
  logic multi_req;
  assign multi_req = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                     (req_valid[1] & req_valid[2]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (iss_stall) stall_cnt    <= stall_cnt + 32'd1;
      if (multi_req) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
